// File: rtl/dual_issue_dispatch_pkg.sv
// MIPS opcode constants, queue entry type and destination-register decode
// shared by the dispatch queue and its pairing checker.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qentry_t;

  typedef struct packed {
    logic       writes;
    logic [4:0] rd;
  } dest_t;

  // R-type writes rd; immediate ALU ops and loads write rt.
  function automatic dest_t dest_reg(input logic [31:0] instr);
    dest_t d;
    d.writes = 1'b0;
    d.rd     = 5'd0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.writes = 1'b1;
        d.rd     = instr[15:11];
      end
      OP_ADDI, OP_ORI, OP_LW: begin
        d.writes = 1'b1;
        d.rd     = instr[20:16];
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dual_issue_dispatch_pair_check.sv
// Combinational pairing rule: can instr2 issue in slot 2 alongside instr1
// (no RAW/WAW inside the pair, one memory op, slot 1 not a control transfer).
module pair_check
  import mips_defs::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        pairable
);

  dest_t d1;
  dest_t d2;
  logic  raw;
  logic  waw;
  logic  mem_conflict;
  logic  ctrl1;
  logic  unused_bits;

  assign d1 = dest_reg(instr1);
  assign d2 = dest_reg(instr2);

  assign raw = d1.writes && (d1.rd != 5'd0) &&
               ((d1.rd == instr2[25:21]) || (d1.rd == instr2[20:16]));
  assign waw = d1.writes && d2.writes && (d1.rd != 5'd0) && (d2.rd == d1.rd);

  assign mem_conflict = is_mem(instr1[31:26]) && is_mem(instr2[31:26]);
  // Anything after a branch/jump in slot 1 may be on the wrong path.
  assign ctrl1 = (instr1[31:26] == OP_BEQ) || (instr1[31:26] == OP_J);

  assign pairable = !(raw || waw || mem_conflict || ctrl1);

  assign unused_bits = ^{instr1[25:21], instr1[10:0], instr2[10:0]};

endmodule

// File: rtl/dual_issue_dispatch.sv
// Instruction queue feeding two decode slots; issues a pair or a single per cycle.
// Optional issue statistics counters are built when DISPATCH_STATS_EN is defined.
module dual_issue_dispatch
  import mips_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrF1,
  input  logic [31:0] InstrF2,
  input  logic [31:0] PCF,
  input  logic        FetchValidF,
  output logic        FetchReadyF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic        ValidD1,
  output logic        ValidD2,
  output logic [4:0]  rsD1,
  output logic [4:0]  rtD1,
  output logic [4:0]  rsD2,
  output logic [4:0]  rtD2
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0] SingleIssueCnt,
  output logic [31:0] DualIssueCnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  qentry_t        mem_q [DEPTH];
  logic [AW-1:0]  head_q, tail_q, head_p1, tail_p1;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     pop_n;
  logic           push;
  logic           issue_en;
  logic           pairable;
  qentry_t        head_e, next_e;

  logic           valid1_q, valid1_d, valid2_q, valid2_d;
  logic [31:0]    pc1_q, pc1_d, pc2_q, pc2_d;
  logic [31:0]    instr1_q, instr1_d, instr2_q, instr2_d;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);
  assign head_e  = mem_q[head_q];
  assign next_e  = mem_q[head_p1];

  assign FetchReadyF = (CW'(DEPTH) - count_q) >= CW'(2);
  assign push        = FetchValidF && FetchReadyF && !FlushD;
  assign issue_en    = !StallD && !FlushD;

  pair_check u_pair_check (
    .instr1   (head_e.instr),
    .instr2   (next_e.instr),
    .pairable (pairable)
  );

  // Queue storage has no reset; only entries inside head..head+count are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q]  <= '{pc: PCF, instr: InstrF1};
      mem_q[tail_p1] <= '{pc: PCF + 32'd4, instr: InstrF2};
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (issue_en) begin
      if ((count_q >= CW'(2)) && pairable) begin
        pop_n = 2'd2;
      end else if (count_q != '0) begin
        pop_n = 2'd1;
      end
    end
  end

  assign count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_n);

  always_comb begin
    valid1_d = valid1_q;
    valid2_d = valid2_q;
    pc1_d    = pc1_q;
    pc2_d    = pc2_q;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    if (FlushD) begin
      valid1_d = 1'b0;
      valid2_d = 1'b0;
      pc1_d    = '0;
      pc2_d    = '0;
      instr1_d = '0;
      instr2_d = '0;
    end else if (!StallD) begin
      valid1_d = (pop_n != 2'd0);
      valid2_d = (pop_n == 2'd2);
      pc1_d    = (pop_n != 2'd0) ? head_e.pc    : 32'd0;
      instr1_d = (pop_n != 2'd0) ? head_e.instr : 32'd0;
      pc2_d    = (pop_n == 2'd2) ? next_e.pc    : 32'd0;
      instr2_d = (pop_n == 2'd2) ? next_e.instr : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      pc1_q    <= '0;
      pc2_q    <= '0;
      instr1_q <= '0;
      instr2_q <= '0;
    end else begin
      if (FlushD) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + AW'(pop_n);
        tail_q  <= push ? tail_q + AW'(2) : tail_q;
        count_q <= count_d;
      end
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      pc1_q    <= pc1_d;
      pc2_q    <= pc2_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
    end
  end

  assign ValidD1 = valid1_q;
  assign ValidD2 = valid2_q;
  assign PCD1    = pc1_q;
  assign PCD2    = pc2_q;
  assign InstrD1 = instr1_q;
  assign InstrD2 = instr2_q;
  assign rsD1    = instr1_q[25:21];
  assign rtD1    = instr1_q[20:16];
  assign rsD2    = instr2_q[25:21];
  assign rtD2    = instr2_q[20:16];

`ifdef DISPATCH_STATS_EN
  logic [31:0] single_cnt_q, dual_cnt_q;

  // pop_n is already zero on stalled or flushed cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      single_cnt_q <= '0;
      dual_cnt_q   <= '0;
    end else begin
      if ((pop_n == 2'd1) && (single_cnt_q != 32'hFFFF_FFFF)) begin
        single_cnt_q <= single_cnt_q + 32'd1;
      end
      if ((pop_n == 2'd2) && (dual_cnt_q != 32'hFFFF_FFFF)) begin
        dual_cnt_q <= dual_cnt_q + 32'd1;
      end
    end
  end

  assign SingleIssueCnt = single_cnt_q;
  assign DualIssueCnt   = dual_cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Scoreboard bench for dual_issue_dispatch: expected issue groups are queued
// when a pair is fetched and compared as the decode slots fill.
module tb_dual_issue_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrF1, InstrF2, PCF;
  logic        FetchValidF, FetchReadyF, StallD, FlushD;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
  logic        ValidD1, ValidD2;
  logic [4:0]  rsD1, rtD1, rsD2, rtD2;
`ifdef DISPATCH_STATS_EN
  logic [31:0] SingleIssueCnt, DualIssueCnt;
`endif

  always #5 clk = ~clk;

  dual_issue_dispatch #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .InstrF1     (InstrF1),
    .InstrF2     (InstrF2),
    .PCF         (PCF),
    .FetchValidF (FetchValidF),
    .FetchReadyF (FetchReadyF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .InstrD1     (InstrD1),
    .InstrD2     (InstrD2),
    .PCD1        (PCD1),
    .PCD2        (PCD2),
    .ValidD1     (ValidD1),
    .ValidD2     (ValidD2),
    .rsD1        (rsD1),
    .rtD1        (rtD1),
    .rsD2        (rsD2),
    .rtD2        (rtD2)
`ifdef DISPATCH_STATS_EN
    ,
    .SingleIssueCnt (SingleIssueCnt),
    .DualIssueCnt   (DualIssueCnt)
`endif
  );

  localparam logic [31:0] I_ADD3  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] I_SUB5  = 32'h0086_2822; // sub $5,$4,$6
  localparam logic [31:0] I_OR7   = 32'h0062_3825; // or  $7,$3,$2
  localparam logic [31:0] I_LW2   = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] I_SW4   = 32'hACA4_0008; // sw  $4,8($5)
  localparam logic [31:0] I_BEQ   = 32'h1022_0004; // beq $1,$2,4
  localparam logic [31:0] I_ADDI3 = 32'h2003_0005; // addi $3,$0,5
  localparam logic [31:0] I_ADD0  = 32'h0022_0020; // add $0,$1,$2
  localparam logic [31:0] I_OR7Z  = 32'h0002_3825; // or  $7,$0,$2

  typedef struct {
    logic        v2;
    logic [31:0] pc1;
    logic [31:0] i1;
    logic [31:0] pc2;
    logic [31:0] i2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] c_i1   [7] = '{I_ADD3, I_ADD3, I_LW2, I_BEQ, I_ADD3,  I_ADD0, I_SUB5};
  logic [31:0] c_i2   [7] = '{I_SUB5, I_OR7,  I_SW4, I_SUB5, I_ADDI3, I_OR7Z, I_BEQ};
  logic        c_pair [7] = '{1'b1,   1'b0,   1'b0,  1'b0,   1'b0,    1'b1,   1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] pc, input logic [31:0] i1,
                            input logic [31:0] i2, input logic pair);
    exp_t e;
    FetchValidF = 1'b1;
    PCF         = pc;
    InstrF1     = i1;
    InstrF2     = i2;
    if (pair) begin
      e = '{v2: 1'b1, pc1: pc, i1: i1, pc2: pc + 32'd4, i2: i2};
      exp_q.push_back(e);
    end else begin
      e = '{v2: 1'b0, pc1: pc, i1: i1, pc2: 32'd0, i2: 32'd0};
      exp_q.push_back(e);
      e = '{v2: 1'b0, pc1: pc + 32'd4, i1: i2, pc2: 32'd0, i2: 32'd0};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    FetchValidF = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    PCF         = '0;
    InstrF1     = '0;
    InstrF2     = '0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, FetchReadyF} !== {2'b00, 128'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b%b i1=%h i2=%h pc1=%h pc2=%h rdy=%b, want all 0 rdy=1",
               ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, FetchReadyF);
    end
    $display("reset: v=%b%b rdy=%b", ValidD1, ValidD2, FetchReadyF);
  endtask

  task automatic test_pairing();
    exp_t e;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_pair(32'h100 + 32'(k) * 32'h40, c_i1[k], c_i2[k], c_pair[k]);
      step();
      FetchValidF = 1'b0;
      for (int cyc = 0; cyc < 4 && exp_q.size() > 0; cyc++) begin
        step();
        e = exp_q.pop_front();
        checks++;
        if ({ValidD1, ValidD2, PCD1, InstrD1, InstrD2} !== {1'b1, e.v2, e.pc1, e.i1, e.i2} ||
            (e.v2 && PCD2 !== e.pc2)) begin
          errors++;
          $display("FAIL pair_case%0d: got v=%b%b pc1=%h i1=%h pc2=%h i2=%h, want v=1%b pc1=%h i1=%h pc2=%h i2=%h",
                   k, ValidD1, ValidD2, PCD1, InstrD1, PCD2, InstrD2, e.v2, e.pc1, e.i1, e.pc2, e.i2);
        end
        if (k == 0) begin
          checks++;
          if (rsD1 !== 5'd1 || rtD1 !== 5'd2 || rsD2 !== 5'd4 || rtD2 !== 5'd6) begin
            errors++;
            $display("FAIL src_regs: got rs1=%0d rt1=%0d rs2=%0d rt2=%0d, want 1 2 4 6",
                     rsD1, rtD1, rsD2, rtD2);
          end
        end
        $display("case %0d issue: v=%b%b pc1=%h i1=%h", k, ValidD1, ValidD2, PCD1, InstrD1);
      end
      step();
      checks++;
      if (ValidD1 !== 1'b0 || ValidD2 !== 1'b0 || InstrD1 !== 32'd0) begin
        errors++;
        $display("FAIL idle_case%0d: got v=%b%b i1=%h, want v=00 i1=0", k, ValidD1, ValidD2, InstrD1);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    drive_pair(32'h200, I_ADD3, I_SUB5, 1'b1);
    step();
    drive_pair(32'h208, I_ADD3, I_SUB5, 1'b1);
    step();
    e = exp_q.pop_front();
    checks++;
    if ({ValidD1, ValidD2, PCD1, PCD2} !== {2'b11, e.pc1, e.pc2}) begin
      errors++;
      $display("FAIL stall_pre: got v=%b%b pc1=%h pc2=%h, want v=11 pc1=%h pc2=%h",
               ValidD1, ValidD2, PCD1, PCD2, e.pc1, e.pc2);
    end
    StallD = 1'b1;
    drive_pair(32'h210, I_ADD3, I_SUB5, 1'b1);
    step();
    PCF = 32'h218; // queue full: this pair must be refused
    for (int cyc = 0; cyc < 2; cyc++) begin
      checks++;
      if (FetchReadyF !== 1'b0 || ValidD1 !== 1'b1 || PCD1 !== 32'h200 || PCD2 !== 32'h204) begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy=%b v1=%b pc1=%h pc2=%h, want rdy=0 v1=1 pc1=00000200 pc2=00000204",
                 cyc, FetchReadyF, ValidD1, PCD1, PCD2);
      end
      $display("stall cycle %0d: rdy=%b pc1=%h", cyc, FetchReadyF, PCD1);
      if (cyc == 0) step();
    end
    StallD      = 1'b0;
    FetchValidF = 1'b0;
    for (int cyc = 0; cyc < 4 && exp_q.size() > 0; cyc++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({ValidD1, ValidD2, PCD1, PCD2} !== {2'b11, e.pc1, e.pc2} || (cyc == 0 && FetchReadyF !== 1'b1)) begin
        errors++;
        $display("FAIL stall_release%0d: got v=%b%b pc1=%h pc2=%h rdy=%b, want v=11 pc1=%h pc2=%h rdy=1",
                 cyc, ValidD1, ValidD2, PCD1, PCD2, FetchReadyF, e.pc1, e.pc2);
      end
      $display("release issue: pc1=%h pc2=%h rdy=%b", PCD1, PCD2, FetchReadyF);
    end
    step();
    checks++;
    if (ValidD1 !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got v1=%b pc1=%h pending=%0d, want v1=0 pending=0",
               ValidD1, PCD1, exp_q.size());
    end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    StallD = 1'b1;
    drive_pair(32'h300, I_ADD3, I_OR7, 1'b0);
    step();
    drive_pair(32'h308, I_ADD3, I_SUB5, 1'b1);
    step();
    StallD      = 1'b0;
    FetchValidF = 1'b0;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({ValidD1, ValidD2, PCD1, InstrD1} !== {2'b10, e.pc1, e.i1}) begin
      errors++;
      $display("FAIL flush_pre: got v=%b%b pc1=%h i1=%h, want v=10 pc1=%h i1=%h",
               ValidD1, ValidD2, PCD1, InstrD1, e.pc1, e.i1);
    end
    exp_q.delete();
    FlushD = 1'b1;
    StallD = 1'b1;
    FetchValidF = 1'b1;
    PCF     = 32'h400;
    InstrF1 = I_ADD3;
    InstrF2 = I_SUB5;
    step();
    FlushD      = 1'b0;
    StallD      = 1'b0;
    FetchValidF = 1'b0;
    checks++;
    if ({ValidD1, ValidD2, InstrD1, InstrD2, FetchReadyF} !== {2'b00, 64'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush: got v=%b%b i1=%h i2=%h rdy=%b, want v=00 i=0 rdy=1",
               ValidD1, ValidD2, InstrD1, InstrD2, FetchReadyF);
    end
    $display("flush: v=%b%b rdy=%b", ValidD1, ValidD2, FetchReadyF);
    for (int cyc = 0; cyc < 2; cyc++) begin
      step();
      checks++;
      if (ValidD1 !== 1'b0 || ValidD2 !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty%0d: got v=%b%b pc1=%h, want v=00", cyc, ValidD1, ValidD2, PCD1);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_pair(32'h500, I_ADD3, I_SUB5, 1'b1);
    step();
    FetchValidF = 1'b0;
    step();
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ValidD1, ValidD2, PCD1, InstrD1, FetchReadyF} !== {2'b00, 64'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got v=%b%b pc1=%h i1=%h rdy=%b, want v=00 0 0 rdy=1",
               ValidD1, ValidD2, PCD1, InstrD1, FetchReadyF);
    end
    $display("async reset: v=%b%b", ValidD1, ValidD2);
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (ValidD1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_empty: got v1=%b pc1=%h, want v1=0", ValidD1, PCD1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        drive_pair(32'h100 + 32'(k) * 32'h8, I_ADD3, I_SUB5, 1'b1);
      end else begin
        FetchValidF = 1'b0;
      end
      step();
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ValidD1, ValidD2, PCD1, PCD2, FetchReadyF} !== {2'b11, e.pc1, e.pc2, 1'b1}) begin
          errors++;
          $display("FAIL b2b_%0d: got v=%b%b pc1=%h pc2=%h rdy=%b, want v=11 pc1=%h pc2=%h rdy=1",
                   k, ValidD1, ValidD2, PCD1, PCD2, FetchReadyF, e.pc1, e.pc2);
        end
        $display("b2b issue: pc1=%h pc2=%h", PCD1, PCD2);
      end
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (DualIssueCnt !== 32'd6 || SingleIssueCnt !== 32'd0) begin
      errors++;
      $display("FAIL stats: got dual=%0d single=%0d, want dual=6 single=0", DualIssueCnt, SingleIssueCnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pairing();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
